voice_mixer: RTL and testbench
==============================

Name: voice_mixer

Overview:
- Parametrised polyphonic mixer that replaces the flat combinational voice sum.
- On each sample strobe it snapshots NUM_VOICES voice samples. It then accumulates them one voice per Clk cycle, applying a per-voice gain and mute.
- The sum is scaled by a master shift, saturated to SAMPLE_W, and presented as a registered output with a valid pulse.
- Sits between the voice array and the audio interface LDATA/RDATA inputs, clocked by the 50 MHz system clock.

Parameters:
- NUM_VOICES, 8, number of voice channels (2..64).
- SAMPLE_W, 16, signed sample width in and out.
- GAIN_W, 8, unsigned gain width; unity = 2^(GAIN_W-1), maximum ≈ 2.0.
- SHIFT_W, 3, width of master_shift.

Ports:
- Clk  in  1  system clock (CLOCK_50 domain).
- Reset_n  in  1  synchronous, active-low reset.
- sample_strobe  in  1  one-cycle pulse requesting a new mix (derived from DACLRCK edge upstream).
- voice_in  in  NUM_VOICES*SAMPLE_W  packed signed samples, voice k at [k*SAMPLE_W +: SAMPLE_W].
- voice_gain  in  NUM_VOICES*GAIN_W  packed unsigned gains.
- voice_mute  in  NUM_VOICES  1 = voice contributes zero.
- master_shift  in  SHIFT_W  extra arithmetic right shift applied to the sum.
- clip_clear  in  1  clears the sticky clip flag.
- mix_out  out  SAMPLE_W  signed mixed sample, held between updates.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- busy  out  1  high while a mix is in progress.
- clip  out  1  sticky; set when saturation occurs.
- overrun  out  1  sticky; set when a strobe is dropped. Cleared only by reset.

Behaviour:
- Reset (Reset_n=0 at a Clk edge):
  - mix_out=0, mix_valid=0, busy=0, clip=0, overrun=0.
  - State goes to IDLE, accumulator=0, voice index=0.
  - A reset mid-mix aborts the mix: no mix_valid, mix_out stays 0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - sample_strobe=1 at edge E0 latches voice_in, voice_gain, voice_mute and master_shift into snapshot registers.
  - On that edge: acc=0, idx=0, state=ACCUM, busy=1.
- ACCUM (edges E1..E_N, N=NUM_VOICES):
  - Each edge: acc += mute[idx] ? 0 : signed(sample[idx]) * {1'b0, gain[idx]}; then idx++.
  - After the edge processing idx=N-1, state=DONE.
- Accumulator width: SAMPLE_W + GAIN_W + 1 + clog2(NUM_VOICES) signed. It never overflows internally.
- DONE (edge E_{N+1}):
  - r = acc >>> (GAIN_W-1 + master_shift_snap), arithmetic shift, floor rounding.
  - If r > 2^(SAMPLE_W-1)-1, mix_out = max positive. If r < -2^(SAMPLE_W-1), mix_out = min negative. Otherwise mix_out = r.
  - If saturation occurred, clip is set to 1.
  - mix_valid=1 for exactly that one cycle; busy=0; state=IDLE.
- Latency:
  - mix_valid is high in the cycle following edge E_{N+1}: N+1 edges after the strobe was sampled.
  - For N=8 that is 9.
- Strobe handling:
  - sample_strobe in ACCUM or DONE is ignored and sets overrun. The in-progress mix continues with its snapshot.
  - The earliest accepted re-strobe is at edge E_{N+2}.
- Input stability: inputs may change while busy; only snapshot values are used.
- clip_clear:
  - Clears clip on the next edge.
  - If a saturation event and clip_clear occur on the same edge, clip stays 1.
- mix_out holds its last value while not updating.

Decomposition:
- Package voice_mixer_pkg:
  - state enum mix_state_t {IDLE, ACCUM, DONE}.
  - Function to compute the accumulator width.
  - Saturate function sat_to_sample(acc, shift).
- Sub-module mix_mac:
  - Registered multiply-accumulate with clear and enable.
  - Signed sample × unsigned gain into the accumulator.
  - Instantiated once by voice_mixer, which owns the FSM, snapshot registers and saturation.

Test Plan (N=8, SAMPLE_W=16, GAIN_W=8):
- Unity sum: all voices 0x1000, gain 128, mute 0, shift 3, one strobe → mix_out=0x1000, clip=0, mix_valid exactly 9 edges after strobe, busy high for cycles 1-9.
- Saturation: all voices 0x7000, gain 128, shift 0 → mix_out=0x7FFF, clip=1. Then all voices 0x9000 → mix_out=0x8000, clip stays 1.
- Gain/mute: voices 1-7 muted, voice0=-100 (0xFF9C), gain 64, shift 0 → mix_out=-50 (0xFFCE).
- Overrun: second strobe 3 cycles after first → ignored, overrun=1, single mix_valid with first-snapshot result. A strobe after idle is then accepted normally.
- Reset mid-mix: Reset_n low for 1 cycle at ACCUM idx=4 → no mix_valid; mix_out=0, busy=0, clip=0. The next strobe produces the correct result.
- Clip clear race: assert clip_clear on the same edge as a saturating DONE → clip=1. clip_clear on a later non-saturating cycle → clip=0.

Source files
------------

// File: rtl/voice_mixer_pkg.sv
// rtl/voice_mixer_pkg.sv - shared types and helpers for the sequential voice mixer
package voice_mixer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } mix_state_t;

    // Working width of the saturation helper; must exceed any accumulator width.
    localparam int SAT_W = 64;

    function automatic int acc_width(input int sample_w, input int gain_w, input int num_voices);
        return sample_w + gain_w + 1 + $clog2(num_voices);
    endfunction

    // Arithmetic right shift (floor) then clamp into a signed sample_w range.
    function automatic logic signed [SAT_W-1:0] sat_to_sample(
        input  logic signed [SAT_W-1:0] acc,
        input  int                      shift,
        input  int                      sample_w,
        output logic                    clipped
    );
        logic signed [SAT_W-1:0] r;
        logic signed [SAT_W-1:0] max_pos;
        logic signed [SAT_W-1:0] min_neg;
        r       = acc >>> shift;
        max_pos = (64'sd1 <<< (sample_w - 1)) - 64'sd1;
        min_neg = -(64'sd1 <<< (sample_w - 1));
        clipped = 1'b0;
        if (r > max_pos) begin
            r       = max_pos;
            clipped = 1'b1;
        end else if (r < min_neg) begin
            r       = min_neg;
            clipped = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/voice_mixer_mac.sv
// rtl/voice_mixer_mac.sv - registered signed-sample by unsigned-gain multiply-accumulate
module mix_mac #(
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 8,
    parameter int ACC_W    = 28
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clear,
    input  logic                       enable,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic        [GAIN_W-1:0]   gain,
    output logic signed [ACC_W-1:0]    acc
);
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

    logic signed [PROD_W-1:0] prod;

    // Zero-extend the gain so it multiplies as a non-negative signed operand.
    assign prod = sample * $signed({1'b0, gain});

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - snapshot, serial gain/mute accumulate, master shift and saturate
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 8,
    parameter int SHIFT_W    = 3
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           sample_strobe,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_in,
    input  logic [NUM_VOICES*GAIN_W-1:0]   voice_gain,
    input  logic [NUM_VOICES-1:0]          voice_mute,
    input  logic [SHIFT_W-1:0]             master_shift,
    input  logic                           clip_clear,
    output logic [SAMPLE_W-1:0]            mix_out,
    output logic                           mix_valid,
    output logic                           busy,
    output logic                           clip,
    output logic                           overrun
);
    localparam int ACC_W = acc_width(SAMPLE_W, GAIN_W, NUM_VOICES);
    localparam int IDX_W = $clog2(NUM_VOICES);

    mix_state_t state, next_state;

    logic [IDX_W-1:0]               idx;
    logic [NUM_VOICES*SAMPLE_W-1:0] snap_voice;
    logic [NUM_VOICES*GAIN_W-1:0]   snap_gain;
    logic [NUM_VOICES-1:0]          snap_mute;
    logic [SHIFT_W-1:0]             snap_shift;

    logic                       load;
    logic                       mac_clear;
    logic                       mac_enable;
    logic                       finish;
    logic signed [ACC_W-1:0]    acc;
    logic signed [SAMPLE_W-1:0] cur_sample;
    logic [GAIN_W-1:0]          cur_gain;
    logic                       cur_mute;
    logic signed [SAT_W-1:0]    acc_ext;
    logic [SAMPLE_W-1:0]        sat_val;
    logic                       sat_clip;

    assign cur_sample = snap_voice[idx*SAMPLE_W +: SAMPLE_W];
    assign cur_gain   = snap_gain[idx*GAIN_W +: GAIN_W];
    assign cur_mute   = snap_mute[idx];
    assign busy       = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        mac_clear  = 1'b0;
        mac_enable = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (sample_strobe) begin
                    load       = 1'b1;
                    mac_clear  = 1'b1;
                    next_state = ACCUM;
                end
            end
            ACCUM: begin
                mac_enable = !cur_mute;
                if (idx == IDX_W'(NUM_VOICES - 1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                finish     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    mix_mac #(
        .SAMPLE_W (SAMPLE_W),
        .GAIN_W   (GAIN_W),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk    (Clk),
        .resetn (Reset_n),
        .clear  (mac_clear),
        .enable (mac_enable),
        .sample (cur_sample),
        .gain   (cur_gain),
        .acc    (acc)
    );

    // The GAIN_W-1 term removes the unity-gain scaling before the master shift.
    always_comb begin
        sat_clip = 1'b0;
        acc_ext  = {{(SAT_W-ACC_W){acc[ACC_W-1]}}, acc};
        sat_val  = SAMPLE_W'(sat_to_sample(acc_ext, GAIN_W - 1 + int'(snap_shift), SAMPLE_W, sat_clip));
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            idx        <= '0;
            snap_voice <= '0;
            snap_gain  <= '0;
            snap_mute  <= '0;
            snap_shift <= '0;
            mix_out    <= '0;
            mix_valid  <= 1'b0;
            clip       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            mix_valid <= finish;
            if (load) begin
                snap_voice <= voice_in;
                snap_gain  <= voice_gain;
                snap_mute  <= voice_mute;
                snap_shift <= master_shift;
                idx        <= '0;
            end else if (state == ACCUM) begin
                idx <= idx + 1'b1;
            end
            if (finish) begin
                mix_out <= sat_val;
            end
            if (finish && sat_clip) begin
                clip <= 1'b1;
            end else if (clip_clear) begin
                clip <= 1'b0;
            end
            if (sample_strobe && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// tb/tb_voice_mixer.sv - directed self-checking bench for voice_mixer
module tb_voice_mixer;
    localparam int N  = 8;
    localparam int SW = 16;
    localparam int GW = 8;
    localparam int HW = 3;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            sample_strobe = 1'b0;
    logic [N*SW-1:0] voice_in = '0;
    logic [N*GW-1:0] voice_gain = '0;
    logic [N-1:0]    voice_mute = '0;
    logic [HW-1:0]   master_shift = '0;
    logic            clip_clear = 1'b0;
    logic [SW-1:0]   mix_out;
    logic            mix_valid;
    logic            busy;
    logic            clip;
    logic            overrun;

    int total = 0;
    int bad   = 0;
    int lat;
    int bcnt;
    int vcnt;

    always #5 clk = ~clk;

    voice_mixer #(.NUM_VOICES(N), .SAMPLE_W(SW), .GAIN_W(GW), .SHIFT_W(HW)) dut (
        .Clk           (clk),
        .Reset_n       (reset_n),
        .sample_strobe (sample_strobe),
        .voice_in      (voice_in),
        .voice_gain    (voice_gain),
        .voice_mute    (voice_mute),
        .master_shift  (master_shift),
        .clip_clear    (clip_clear),
        .mix_out       (mix_out),
        .mix_valid     (mix_valid),
        .busy          (busy),
        .clip          (clip),
        .overrun       (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [SW-1:0] s, input logic [GW-1:0] g,
                           input logic [N-1:0] m, input logic [HW-1:0] sh);
        for (int k = 0; k < N; k++) begin
            voice_in[k*SW +: SW]   = s;
            voice_gain[k*GW +: GW] = g;
        end
        voice_mute   = m;
        master_shift = sh;
    endtask

    // Returns at the falling edge just after the strobe has been sampled.
    task automatic do_strobe();
        @(negedge clk);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
    endtask

    task automatic wait_valid(output int l, output int b);
        l = 0;
        b = 0;
        while (mix_valid !== 1'b1 && l < 40) begin
            if (busy === 1'b1) b++;
            @(negedge clk);
            l++;
        end
    endtask

    task automatic count_valids(input int cycles, output int c);
        c = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (mix_valid === 1'b1) c++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_mix_out", 32'(mix_out), 32'h0);
        check("reset_valid", 32'(mix_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_clip", 32'(clip), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        reset_n = 1'b1;

        // 8 * 0x1000 at unity, shift 3 -> 0x1000
        set_all(16'h1000, 8'd128, 8'h00, 3'd3);
        do_strobe();
        check("unity_busy_start", 32'(busy), 32'h1);
        wait_valid(lat, bcnt);
        check("unity_latency", 32'(lat), 32'd9);
        check("unity_busy_cycles", 32'(bcnt), 32'd9);
        check("unity_mix_out", 32'(mix_out), 32'h1000);
        check("unity_clip", 32'(clip), 32'h0);
        check("unity_busy_end", 32'(busy), 32'h0);
        @(negedge clk);
        check("unity_valid_pulse", 32'(mix_valid), 32'h0);
        check("unity_hold", 32'(mix_out), 32'h1000);

        set_all(16'h7000, 8'd128, 8'h00, 3'd0);
        do_strobe();
        wait_valid(lat, bcnt);
        check("sat_pos_out", 32'(mix_out), 32'h7FFF);
        check("sat_pos_clip", 32'(clip), 32'h1);

        set_all(16'h9000, 8'd128, 8'h00, 3'd0);
        do_strobe();
        wait_valid(lat, bcnt);
        check("sat_neg_out", 32'(mix_out), 32'h8000);
        check("sat_neg_clip", 32'(clip), 32'h1);

        // clip_clear held through a saturating mix: set wins on the DONE edge
        set_all(16'h7000, 8'd128, 8'h00, 3'd0);
        clip_clear = 1'b1;
        do_strobe();
        wait_valid(lat, bcnt);
        clip_clear = 1'b0;
        check("race_out", 32'(mix_out), 32'h7FFF);
        check("race_clip", 32'(clip), 32'h1);
        @(negedge clk);
        check("race_clip_held", 32'(clip), 32'h1);
        clip_clear = 1'b1;
        @(negedge clk);
        clip_clear = 1'b0;
        check("clip_cleared", 32'(clip), 32'h0);

        // voice0 = -100 at gain 64, others muted -> -50
        set_all(16'h1234, 8'd128, 8'hFE, 3'd0);
        voice_in[0 +: SW]   = 16'hFF9C;
        voice_gain[0 +: GW] = 8'd64;
        do_strobe();
        wait_valid(lat, bcnt);
        check("gain_mute_out", 32'(mix_out), 32'h0000FFCE);
        check("gain_mute_clip", 32'(clip), 32'h0);

        // voice k = 256*(k+1), gain 32*(k%4+1), shift 2 -> 819200>>>9 = 1600
        set_all(16'h0, 8'd0, 8'h00, 3'd2);
        for (int k = 0; k < N; k++) begin
            voice_in[k*SW +: SW]   = 16'((k + 1) * 256);
            voice_gain[k*GW +: GW] = 8'(32 * (k % 4 + 1));
        end
        do_strobe();
        wait_valid(lat, bcnt);
        check("per_voice_out", 32'(mix_out), 32'h0640);

        // -3 * 128 >>> 8 = -1.5, floors to -2
        set_all(16'h0777, 8'd128, 8'hFE, 3'd1);
        voice_in[0 +: SW] = 16'hFFFD;
        do_strobe();
        wait_valid(lat, bcnt);
        check("floor_out", 32'(mix_out), 32'h0000FFFE);
        check("pre_overrun", 32'(overrun), 32'h0);

        // re-strobe 3 cycles in with changed inputs: dropped, first snapshot used
        set_all(16'h1000, 8'd128, 8'h00, 3'd3);
        do_strobe();
        @(negedge clk);
        @(negedge clk);
        set_all(16'h2000, 8'd128, 8'h00, 3'd3);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        check("overrun_set", 32'(overrun), 32'h1);
        wait_valid(lat, bcnt);
        check("overrun_latency", 32'(lat), 32'd6);
        check("overrun_out", 32'(mix_out), 32'h1000);
        count_valids(15, vcnt);
        check("overrun_single_valid", 32'(vcnt), 32'd0);
        do_strobe();
        wait_valid(lat, bcnt);
        check("after_overrun_out", 32'(mix_out), 32'h2000);
        check("after_overrun_lat", 32'(lat), 32'd9);
        check("overrun_sticky", 32'(overrun), 32'h1);

        set_all(16'h7000, 8'd128, 8'h00, 3'd0);
        do_strobe();
        wait_valid(lat, bcnt);
        check("pre_reset_clip", 32'(clip), 32'h1);

        // reset pulse once idx has reached 4
        set_all(16'h1000, 8'd128, 8'h00, 3'd3);
        do_strobe();
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        count_valids(15, vcnt);
        check("abort_no_valid", 32'(vcnt), 32'd0);
        check("abort_mix_out", 32'(mix_out), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_clip", 32'(clip), 32'h0);
        check("abort_overrun", 32'(overrun), 32'h0);
        do_strobe();
        wait_valid(lat, bcnt);
        check("post_abort_out", 32'(mix_out), 32'h1000);
        check("post_abort_lat", 32'(lat), 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
